// File: rtl/alarm_pkg.sv
// +------------------------------------------------------------------+
// | alarm_pkg: shared types and constants for the alarm controller.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  localparam int HOURS_PER_DAY    = 24;
  localparam int MINUTES_PER_HOUR = 60;
  localparam int TIME_W           = 7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_time_register.sv
// +------------------------------------------------------------------+
// | alarm_time_register: stored alarm hour/minute with set-mode      |
// | per-tick increment and independent field wrap. Rev 1.0           |
// +------------------------------------------------------------------+
`default_nettype none

module alarm_time_register
  import alarm_pkg::*;
#(
  parameter int DEFAULT_HOUR   = 6,
  parameter int DEFAULT_MINUTE = 0
) (
  input  logic              clock_1_second,
  input  logic              reset,
  input  logic              set_alarm,
  input  logic              inc_hour,
  input  logic              inc_minute,
  output logic [TIME_W-1:0] alarm_hour,
  output logic [TIME_W-1:0] alarm_minute
);

  localparam logic [TIME_W-1:0] c_last_hour   = TIME_W'(HOURS_PER_DAY - 1);
  localparam logic [TIME_W-1:0] c_last_minute = TIME_W'(MINUTES_PER_HOUR - 1);
  localparam logic [TIME_W-1:0] c_reset_hour  = TIME_W'(DEFAULT_HOUR);
  localparam logic [TIME_W-1:0] c_reset_min   = TIME_W'(DEFAULT_MINUTE);

  // Minutes wrap without carrying into the hour field.
  always_ff @(posedge clock_1_second) begin
    if (reset) begin
      alarm_hour   <= c_reset_hour;
      alarm_minute <= c_reset_min;
    end else if (set_alarm) begin
      if (inc_hour)
        alarm_hour <= (alarm_hour == c_last_hour) ? '0 : alarm_hour + 1'b1;
      if (inc_minute)
        alarm_minute <= (alarm_minute == c_last_minute) ? '0 : alarm_minute + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alarm_controller.sv
// +------------------------------------------------------------------+
// | alarm_controller: alarm trigger compare plus ring/snooze FSM     |
// | driving the buzzer and snooze indicator. Rev 1.0                 |
// +------------------------------------------------------------------+
`default_nettype none

module alarm_controller
  import alarm_pkg::*;
#(
  parameter int DEFAULT_HOUR   = 6,
  parameter int DEFAULT_MINUTE = 0,
  parameter int RING_TIMEOUT   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic                               clock_1_second,
  input  logic                               reset,
  input  logic [TIME_W-1:0]                  cur_hour,
  input  logic [TIME_W-1:0]                  cur_minute,
  input  logic [TIME_W-1:0]                  cur_second,
  input  logic                               alarm_enable,
  input  logic                               set_alarm,
  input  logic                               inc_hour,
  input  logic                               inc_minute,
  input  logic                               snooze,
  input  logic                               stop,
  output logic [TIME_W-1:0]                  alarm_hour,
  output logic [TIME_W-1:0]                  alarm_minute,
  output logic                               ringing,
  output logic                               snoozing,
  output logic [$clog2(MAX_SNOOZES+1)-1:0]   snooze_count
);

  localparam int TIMER_W = $clog2(max_int(RING_TIMEOUT, SNOOZE_SECONDS));
  localparam int COUNT_W = $clog2(MAX_SNOOZES + 1);

  localparam logic [TIMER_W-1:0] c_ring_last   = TIMER_W'(RING_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] c_snooze_last = TIMER_W'(SNOOZE_SECONDS - 1);
  localparam logic [COUNT_W-1:0] c_max_snoozes = COUNT_W'(MAX_SNOOZES);

  alarm_state_t       r_state, w_next_state;
  logic [TIMER_W-1:0] r_timer, w_next_timer;
  logic [COUNT_W-1:0] w_next_count;
  logic               w_match;

  alarm_time_register #(
    .DEFAULT_HOUR  (DEFAULT_HOUR),
    .DEFAULT_MINUTE(DEFAULT_MINUTE)
  ) u_time_register (
    .clock_1_second(clock_1_second),
    .reset         (reset),
    .set_alarm     (set_alarm),
    .inc_hour      (inc_hour),
    .inc_minute    (inc_minute),
    .alarm_hour    (alarm_hour),
    .alarm_minute  (alarm_minute)
  );

  // Second-zero qualifier limits the match to a single tick per day.
  assign w_match = (cur_hour == alarm_hour) && (cur_minute == alarm_minute) &&
                   (cur_second == '0);

  always_comb begin
    w_next_state = r_state;
    w_next_timer = '0;
    w_next_count = snooze_count;
    if (set_alarm || !alarm_enable) begin
      w_next_state = IDLE;
      w_next_count = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_match)
            w_next_state = RINGING;
        end
        RINGING: begin
          if (stop) begin
            w_next_state = IDLE;
            w_next_count = '0;
          end else if (snooze && (snooze_count < c_max_snoozes)) begin
            w_next_state = SNOOZE;
            w_next_count = snooze_count + 1'b1;
          end else if (r_timer == c_ring_last) begin
            w_next_state = IDLE;
            w_next_count = '0;
          end else begin
            w_next_timer = r_timer + 1'b1;
          end
        end
        SNOOZE: begin
          if (stop) begin
            w_next_state = IDLE;
            w_next_count = '0;
          end else if (r_timer == c_snooze_last) begin
            w_next_state = RINGING;
          end else begin
            w_next_timer = r_timer + 1'b1;
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_count = '0;
        end
      endcase
    end
  end

  // Indicators are registered from the next state so they track r_state exactly.
  always_ff @(posedge clock_1_second) begin
    if (reset) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      snooze_count <= '0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_timer      <= w_next_timer;
      snooze_count <= w_next_count;
      ringing      <= (w_next_state == RINGING);
      snoozing     <= (w_next_state == SNOOZE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alarm_controller.sv
// Scoreboard bench for alarm_controller: directed per-tick vectors, expected
// outputs queued by the driver and checked by an independent monitor.
`default_nettype none

module tb_alarm_controller;

  logic       clock_1_second;
  logic       reset;
  logic [6:0] cur_hour, cur_minute, cur_second;
  logic       alarm_enable, set_alarm, inc_hour, inc_minute, snooze, stop;
  logic [6:0] alarm_hour, alarm_minute;
  logic       ringing, snoozing;
  logic [1:0] snooze_count;

  alarm_controller #(
    .DEFAULT_HOUR  (6),
    .DEFAULT_MINUTE(0),
    .RING_TIMEOUT  (4),
    .SNOOZE_SECONDS(5),
    .MAX_SNOOZES   (2)
  ) dut (
    .clock_1_second(clock_1_second),
    .reset         (reset),
    .cur_hour      (cur_hour),
    .cur_minute    (cur_minute),
    .cur_second    (cur_second),
    .alarm_enable  (alarm_enable),
    .set_alarm     (set_alarm),
    .inc_hour      (inc_hour),
    .inc_minute    (inc_minute),
    .snooze        (snooze),
    .stop          (stop),
    .alarm_hour    (alarm_hour),
    .alarm_minute  (alarm_minute),
    .ringing       (ringing),
    .snoozing      (snoozing),
    .snooze_count  (snooze_count)
  );

  initial clock_1_second = 1'b0;
  always #5 clock_1_second = ~clock_1_second;

  typedef struct {
    int         id;
    logic [6:0] h;
    logic [6:0] m;
    logic       r;
    logic       s;
    logic [1:0] c;
  } exp_t;

  exp_t       sb_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         vec_id      = 0;
  logic [6:0] exp_h, exp_m;

  task automatic tick(input logic r, input logic s, input logic [1:0] c);
    exp_t e;
    e.id = vec_id;
    e.h  = exp_h;
    e.m  = exp_m;
    e.r  = r;
    e.s  = s;
    e.c  = c;
    vec_id++;
    sb_q.push_back(e);
    @(posedge clock_1_second);
    @(negedge clock_1_second);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hour   = 7'(h);
    cur_minute = 7'(m);
    cur_second = 7'(s);
  endtask

  always begin : monitor
    exp_t e;
    @(posedge clock_1_second);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (alarm_hour !== e.h || alarm_minute !== e.m || ringing !== e.r ||
          snoozing !== e.s || snooze_count !== e.c) begin
        miscompares++;
        $display("FAIL vec%0d: got h=%0d m=%0d ring=%0b snz=%0b cnt=%0d, expected h=%0d m=%0d ring=%0b snz=%0b cnt=%0d",
                 e.id, alarm_hour, alarm_minute, ringing, snoozing, snooze_count,
                 e.h, e.m, e.r, e.s, e.c);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1'b1; alarm_enable = 1'b0; set_alarm = 1'b0;
    inc_hour = 1'b0; inc_minute = 1'b0; snooze = 1'b0; stop = 1'b0;
    set_cur(12, 0, 30);
    exp_h = 7'd6; exp_m = 7'd0;
    tick(0, 0, 2'd0);
    tick(0, 0, 2'd0);
    reset = 1'b0;
    tick(0, 0, 2'd0);

    // Hour wrap: 6 + 20 -> 2
    set_alarm = 1'b1; inc_hour = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      exp_h = 7'((6 + i) % 24);
      tick(0, 0, 2'd0);
    end
    inc_hour = 1'b0; inc_minute = 1'b1;
    for (int i = 1; i <= 61; i++) begin
      exp_m = 7'(i % 60);
      tick(0, 0, 2'd0);
    end
    inc_hour = 1'b1;
    exp_h = 7'd3; exp_m = 7'd2;
    tick(0, 0, 2'd0);
    set_alarm = 1'b0;
    tick(0, 0, 2'd0);

    // Move the alarm to 07:30
    set_alarm = 1'b1; inc_minute = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_h = 7'(3 + i);
      tick(0, 0, 2'd0);
    end
    inc_hour = 1'b0; inc_minute = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      exp_m = 7'(2 + i);
      tick(0, 0, 2'd0);
    end
    inc_minute = 1'b0; set_alarm = 1'b0;

    // Trigger then stop
    alarm_enable = 1'b1;
    set_cur(7, 29, 59); tick(0, 0, 2'd0);
    set_cur(7, 30, 0);  tick(1, 0, 2'd0);
    set_cur(7, 30, 1);  stop = 1'b1; tick(0, 0, 2'd0);
    stop = 1'b0;

    // Auto-stop after four ringing ticks, matching time held throughout
    set_cur(7, 30, 0);
    tick(1, 0, 2'd0);
    repeat (3) tick(1, 0, 2'd0);
    tick(0, 0, 2'd0);
    set_cur(7, 30, 1);
    tick(0, 0, 2'd0);

    // Snooze cycles up to the limit, then an ignored snooze and auto-stop
    set_cur(7, 30, 0); tick(1, 0, 2'd0);
    set_cur(7, 30, 1); snooze = 1'b1;
    tick(0, 1, 2'd1);
    tick(0, 1, 2'd1);
    snooze = 1'b0;
    repeat (3) tick(0, 1, 2'd1);
    tick(1, 0, 2'd1);
    snooze = 1'b1; tick(0, 1, 2'd2);
    snooze = 1'b0;
    repeat (4) tick(0, 1, 2'd2);
    tick(1, 0, 2'd2);
    snooze = 1'b1;
    repeat (3) tick(1, 0, 2'd2);
    tick(0, 0, 2'd0);
    snooze = 1'b0;

    // Cancel from SNOOZE via enable, set mode and reset
    set_cur(7, 30, 0); tick(1, 0, 2'd0);
    set_cur(7, 30, 1); snooze = 1'b1; tick(0, 1, 2'd1);
    snooze = 1'b0; alarm_enable = 1'b0; tick(0, 0, 2'd0);
    alarm_enable = 1'b1;

    set_cur(7, 30, 0); tick(1, 0, 2'd0);
    set_cur(7, 30, 1); snooze = 1'b1; tick(0, 1, 2'd1);
    snooze = 1'b0; set_alarm = 1'b1; tick(0, 0, 2'd0);
    set_alarm = 1'b0;

    set_cur(7, 30, 0); tick(1, 0, 2'd0);
    set_cur(7, 30, 1); snooze = 1'b1; tick(0, 1, 2'd1);
    snooze = 1'b0; reset = 1'b1;
    exp_h = 7'd6; exp_m = 7'd0;
    tick(0, 0, 2'd0);
    reset = 1'b0;

    // Alarm set to 09:15 after second zero has passed: no late trigger
    set_cur(9, 15, 20);
    set_alarm = 1'b1; inc_hour = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_h = 7'(6 + i);
      tick(0, 0, 2'd0);
    end
    inc_hour = 1'b0; inc_minute = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      exp_m = 7'(i);
      tick(0, 0, 2'd0);
    end
    inc_minute = 1'b0; set_alarm = 1'b0;
    for (int s = 20; s <= 59; s++) begin
      set_cur(9, 15, s);
      tick(0, 0, 2'd0);
    end
    set_cur(9, 16, 0); tick(0, 0, 2'd0);
    set_cur(9, 15, 0); tick(1, 0, 2'd0);
    set_cur(9, 15, 1); stop = 1'b1; tick(0, 0, 2'd0);
    stop = 1'b0;

    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
